// File: rtl/fifo_rd_pack_m.sv
// ---------------------------------------------------------------------------
// fifo_rd_pack_m
//
// Read-side packer for a first-word-fall-through FIFO. It runs in the FIFO's
// read clock domain. It pops narrow FIFO words and packs RATIO consecutive
// words into one wide word. The wide word is presented on a registered
// valid/ready output. With out_ready held high the packer sustains one pop
// per clock, and a completed word hands over without a bubble.
//
// Parameters:
//   IN_W   width of one FIFO word (>= 1)
//   RATIO  FIFO words per output word (>= 2)
//
// Ports:
//   clk          clock (FIFO read clock)
//   rst          asynchronous active-high reset
//   head         FIFO head word, valid while empty = 0
//   empty        FIFO empty flag
//   rd_rst_busy  FIFO read-side reset in progress; blocks popping
//   pop          FIFO read enable (combinational)
//   out_data     packed word; the first popped word sits in the low lane
//   out_valid    out_data valid
//   out_ready    downstream accepts out_data
//
// Optional build macro FIFO_RD_PACK_FLUSH_EN adds these ports:
//   flush        request emission of a partially filled word
//   out_lanes    number of valid lanes in out_data
// ---------------------------------------------------------------------------
module fifo_rd_pack_m #(
  parameter int IN_W  = 8,
  parameter int RATIO = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IN_W-1:0]            head,
  input  logic                       empty,
  input  logic                       rd_rst_busy,
  output logic                       pop,
  output logic [IN_W*RATIO-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready
`ifdef FIFO_RD_PACK_FLUSH_EN
  ,
  input  logic                       flush,
  output logic [$clog2(RATIO+1)-1:0] out_lanes
`endif
);

  localparam int CNT_W  = $clog2(RATIO);
  localparam int ACC_W  = (RATIO - 1) * IN_W;
  localparam int OUT_W  = IN_W * RATIO;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

  generate
    if (RATIO < 2) begin : g_ratio_check
      $error("fifo_rd_pack_m: RATIO must be at least 2");
    end
  endgenerate

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  // -------------------------------------------------------------------------
  // Pop control
  // -------------------------------------------------------------------------
  logic slot_free;
  logic cnt_last;
  logic pop_block;
  logic complete;

  assign slot_free = !out_valid_q || out_ready;
  assign cnt_last  = (cnt_q == CNT_LAST);

`ifdef FIFO_RD_PACK_FLUSH_EN
  localparam int LANE_W = $clog2(RATIO + 1);

  logic              flag_q, flag_d;
  logic [LANE_W-1:0] lanes_q, lanes_d;
  logic              pend;
  logic              flush_fire;
  logic [LANE_W-1:0] lanes_now;
  logic [OUT_W-1:0]  partial_word;

  // A fresh flush request counts as pending in the same cycle it arrives.
  assign pend       = flag_q || flush;
  assign flush_fire = pend && slot_free;
  // While a flush waits for the output slot, the last lane must stay empty.
  // Otherwise a full word would complete and the flush would be lost.
  assign pop_block  = pend && cnt_last;
`else
  assign pop_block  = 1'b0;
`endif

  // rst is part of the term so that pop is low during reset, even while the
  // asynchronous reset has not yet reached the registers.
  assign pop = !rst && !empty && !rd_rst_busy
               && (!cnt_last || slot_free) && !pop_block;

  // A pop into the last lane always has a free slot because of the pop term.
  assign complete = pop && cnt_last;

  // -------------------------------------------------------------------------
  // Accumulator lanes. The current lane takes head on a pop. A pop into the
  // last lane never writes here, because that word goes straight to the
  // output register.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < RATIO - 1; gi++) begin : g_acc
      assign acc_d[gi*IN_W +: IN_W] = (pop && (cnt_q == CNT_W'(gi)))
                                      ? head
                                      : acc_q[gi*IN_W +: IN_W];
    end
  endgenerate

`ifdef FIFO_RD_PACK_FLUSH_EN
  // Partial word layout:
  //   - Lanes below cnt come from the accumulator.
  //   - The lane at cnt takes head if a pop happens this cycle.
  //   - All other lanes are zero.
  // The last lane is never filled here, because popping into it is blocked
  // while a flush is pending.
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_partial
      if (gi < RATIO - 1) begin : g_mid
        assign partial_word[gi*IN_W +: IN_W] =
          (cnt_q > CNT_W'(gi))                ? acc_q[gi*IN_W +: IN_W] :
          (pop && (cnt_q == CNT_W'(gi)))      ? head                   :
                                                {IN_W{1'b0}};
      end else begin : g_top
        assign partial_word[gi*IN_W +: IN_W] = {IN_W{1'b0}};
      end
    end
  endgenerate

  // pop adds one lane when it is high and nothing when it is low.
  assign lanes_now = LANE_W'(cnt_q) + LANE_W'(pop);
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    // A transfer empties the slot unless a new word is loaded below.
    out_valid_d = out_valid_q && !out_ready;

    if (pop) begin
      cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
    end

    if (complete) begin
      out_data_d  = {head, acc_q};
      out_valid_d = 1'b1;
    end

`ifdef FIFO_RD_PACK_FLUSH_EN
    lanes_d = lanes_q;
    flag_d  = pend && !flush_fire;

    if (complete) begin
      lanes_d = LANE_W'(RATIO);
    end

    // complete and flush_fire never occur together, because pop_block
    // stops the completing pop whenever a flush is pending.
    if (flush_fire) begin
      cnt_d = '0;
      // A flush with nothing accumulated emits nothing.
      if (lanes_now != '0) begin
        out_data_d  = partial_word;
        out_valid_d = 1'b1;
        lanes_d     = lanes_now;
      end
    end
`endif
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef FIFO_RD_PACK_FLUSH_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q  <= 1'b0;
      lanes_q <= '0;
    end else begin
      flag_q  <= flag_d;
      lanes_q <= lanes_d;
    end
  end

  assign out_lanes = lanes_q;
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fifo_rd_pack_m.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_pack_m
//
// Directed testbench for fifo_rd_pack_m with IN_W = 8 and RATIO = 4.
// A queue models the FWFT FIFO. Its front entry drives head, and it pops on
// every clock where pop was high. Outputs are sampled on the falling edge.
// Define FIFO_RD_PACK_FLUSH_EN to also cover the flush feature.
// ---------------------------------------------------------------------------
module tb_fifo_rd_pack_m;

  localparam int IN_W  = 8;
  localparam int RATIO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  head;
  logic        empty;
  logic        rd_rst_busy;
  logic        pop;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
`ifdef FIFO_RD_PACK_FLUSH_EN
  logic        flush;
  logic [2:0]  out_lanes;
`endif

  logic [7:0]  fifo[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          pop_cnt = 0;
  logic [31:0] exp2 [3] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};

  always #5 clk = ~clk;

  fifo_rd_pack_m #(.IN_W(IN_W), .RATIO(RATIO)) dut (
    .clk         (clk),
    .rst         (rst),
    .head        (head),
    .empty       (empty),
    .rd_rst_busy (rd_rst_busy),
    .pop         (pop),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
`ifdef FIFO_RD_PACK_FLUSH_EN
    ,
    .flush       (flush),
    .out_lanes   (out_lanes)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic upd();
    head  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    empty = (fifo.size() == 0);
  endtask

  task automatic push(input logic [7:0] w);
    fifo.push_back(w);
    upd();
  endtask

  // One clock step. Call it from the falling edge; it returns at the next
  // falling edge. pop is sampled once the inputs have settled, and the
  // model FIFO advances just after the rising edge.
  task automatic step();
    logic p;
    #1;
    p = pop;
    check("pop_guard", p & (empty | rd_rst_busy), 1'b0);
    @(posedge clk);
    #1;
    if (p) begin
      pop_cnt++;
      if (fifo.size() != 0) void'(fifo.pop_front());
    end
    upd();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    head        = 8'h00;
    empty       = 1'b1;
    rd_rst_busy = 1'b0;
    out_ready   = 1'b1;
`ifdef FIFO_RD_PACK_FLUSH_EN
    flush       = 1'b0;
`endif
    repeat (2) @(negedge clk);

    // ---- Test 1: reset state, then one word of four pops ----
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    #1;
    check("rst_pop",   pop,       1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_data",  out_data,  32'h0);
`ifdef FIFO_RD_PACK_FLUSH_EN
    check("rst_lanes", out_lanes, 3'd0);
`endif
    rst = 1'b0;
    #1;
    pop_cnt = 0;
    check("t1_pop_first", pop, 1'b1);
    repeat (3) begin
      step();
      check("t1_pop_run",  pop,       1'b1);
      check("t1_no_valid", out_valid, 1'b0);
    end
    step();
    check("t1_pops",      pop_cnt,   4);
    check("t1_valid",     out_valid, 1'b1);
    check("t1_data",      out_data,  32'h44332211);
`ifdef FIFO_RD_PACK_FLUSH_EN
    check("t1_lanes",     out_lanes, 3'd4);
`endif
    check("t1_pop_empty", pop,       1'b0);
    step();
    check("t1_valid_1clk", out_valid, 1'b0);

    // ---- Test 2: twelve words streamed with out_ready held high ----
    pop_cnt = 0;
    for (int k = 1; k <= 12; k++) push(8'(k));
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k % 4 == 0) begin
        check("t2_valid", out_valid, 1'b1);
        check("t2_data",  out_data,  exp2[k/4-1]);
      end else begin
        check("t2_idle",  out_valid, 1'b0);
      end
    end
    check("t2_no_gap", pop_cnt, 12);
    step();
    check("t2_drain", out_valid, 1'b0);

    // ---- Test 3: downstream stall, then release without a bubble ----
    out_ready = 1'b0;
    pop_cnt   = 0;
    for (int k = 8'h21; k <= 8'h2C; k++) push(8'(k));
    repeat (4) step();
    check("t3_held_valid", out_valid, 1'b1);
    check("t3_held_data",  out_data,  32'h24232221);
    repeat (3) step();
    check("t3_stall_pop",  pop,       1'b0);
    check("t3_stall_cnt",  pop_cnt,   7);
    repeat (2) step();
    check("t3_still_pop",  pop,       1'b0);
    check("t3_still_cnt",  pop_cnt,   7);
    check("t3_still_data", out_data,  32'h24232221);
    check("t3_still_vld",  out_valid, 1'b1);
    out_ready = 1'b1;
    #1;
    check("t3_resume_pop", pop, 1'b1);
    step();
    check("t3_no_bubble",  out_valid, 1'b1);
    check("t3_next_data",  out_data,  32'h28272625);
    repeat (4) step();
    check("t3_last_valid", out_valid, 1'b1);
    check("t3_last_data",  out_data,  32'h2C2B2A29);
    step();
    check("t3_drain",      out_valid, 1'b0);

    // ---- Test 4: rd_rst_busy freezes packing mid-word ----
    push(8'h31); push(8'h32); push(8'h33); push(8'h34);
    repeat (2) step();
    rd_rst_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_busy_pop", pop, 1'b0);
    end
    check("t4_fifo_kept", fifo.size(), 2);
    check("t4_no_valid",  out_valid,   1'b0);
    rd_rst_busy = 1'b0;
    repeat (2) step();
    check("t4_valid", out_valid, 1'b1);
    check("t4_data",  out_data,  32'h34333231);
    step();
    check("t4_drain", out_valid, 1'b0);

    // ---- Test 5: asynchronous reset discards a partial word ----
    out_ready = 1'b0;
    push(8'h51); push(8'h52); push(8'h53); push(8'h54);
    push(8'h41); push(8'h42);
    repeat (6) step();
    check("t5_pre_valid", out_valid, 1'b1);
    check("t5_pre_data",  out_data,  32'h54535251);
    rst = 1'b1;
    #1;
    check("t5_async_vld",  out_valid, 1'b0);
    check("t5_async_data", out_data,  32'h0);
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
    repeat (4) step();
    check("t5_valid", out_valid, 1'b1);
    check("t5_data",  out_data,  32'hA3A2A1A0);
    step();
    check("t5_drain", out_valid, 1'b0);

`ifdef FIFO_RD_PACK_FLUSH_EN
    // ---- Test 6: flush of a partial word, and a flush that is ignored ----
    push(8'h55); push(8'h66);
    repeat (2) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t6_valid", out_valid, 1'b1);
    check("t6_data",  out_data,  32'h00006655);
    check("t6_lanes", out_lanes, 3'd2);
    step();
    check("t6_drain", out_valid, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t6_ign_valid", out_valid, 1'b0);
    push(8'h71); push(8'h72); push(8'h73); push(8'h74);
    step();
    check("t6_ign_noemit", out_valid, 1'b0);
    repeat (3) step();
    check("t6_full_valid", out_valid, 1'b1);
    check("t6_full_data",  out_data,  32'h74737271);
    check("t6_full_lanes", out_lanes, 3'd4);
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
